// File: rtl/branch_update_queue.sv
// -----------------------------------------------------------------------------
// branch_update_queue
//
// Serialises resolved-branch outcomes from the two BRU lanes into the
// single-port br_update interface of the branch prediction unit. The BTB
// takes one update per cycle, so any surplus resolution is parked in an
// in-order FIFO and drained one entry per cycle. When the FIFO is empty, a
// resolution bypasses straight into the output register (1-cycle latency).
//
// Handshake: res_ready_o is high while at least two FIFO entries are free
// (count <= DEPTH-2). A producer may raise res0/res1_valid_i only while
// res_ready_o is high. There is no per-lane ready. Inputs offered while the
// FIFO lacks room are dropped youngest-first, and the drop sets the sticky
// overflow_o.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 discard queued and same-cycle incoming updates
//   res{0,1}_valid_i        lane resolution valid (lane 0 is older)
//   res{0,1}_taken_i        lane actual outcome
//   res{0,1}_pc_i           lane branch PC
//   res{0,1}_target_i       lane actual target
//   res_ready_o             room for two more entries
//   br_update_o             update strobe (registered)
//   br_update_taken_o       update outcome (holds when no update)
//   br_update_PC_o          update PC (holds when no update)
//   br_update_target_o      update target (holds when no update)
//   count_o                 FIFO occupancy, excluding the output register
//   overflow_o              sticky drop indicator, cleared only by reset
// -----------------------------------------------------------------------------
module branch_update_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     res0_valid_i,
    input  logic                     res0_taken_i,
    input  logic [31:0]              res0_pc_i,
    input  logic [31:0]              res0_target_i,
    input  logic                     res1_valid_i,
    input  logic                     res1_taken_i,
    input  logic [31:0]              res1_pc_i,
    input  logic [31:0]              res1_target_i,
    output logic                     res_ready_o,
    output logic                     br_update_o,
    output logic                     br_update_taken_o,
    output logic [31:0]              br_update_PC_o,
    output logic [31:0]              br_update_target_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 65;  // {taken, pc[31:0], target[31:0]}
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M2 = CNT_W'(DEPTH - 2);

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             upd_q, upd_d;
    logic [ENT_W-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;

    logic [ENT_W-1:0] lane0_ent, lane1_ent, head_ent;
    logic             fifo_nonempty;
    logic             pop;
    logic             wa_req, wb_req;
    logic [ENT_W-1:0] wa_ent, wb_ent;
    logic             wa_en, wb_en;
    logic             drop;
    logic [1:0]       n_wr;

    assign lane0_ent     = {res0_taken_i, res0_pc_i, res0_target_i};
    assign lane1_ent     = {res1_taken_i, res1_pc_i, res1_target_i};
    assign head_ent      = mem_q[rd_ptr_q];
    assign fifo_nonempty = (count_q != '0);
    assign wr_ptr_p1     = wr_ptr_q + PTR_W'(1);

    // Candidate selection: the oldest of {FIFO head, lane 0, lane 1} goes to
    // the output register; the rest are write requests in age order
    // (slot a before slot b).
    always_comb begin
        upd_d  = 1'b0;
        out_d  = out_q;
        wa_req = 1'b0;
        wb_req = 1'b0;
        wa_ent = lane0_ent;
        wb_ent = lane1_ent;
        if (fifo_nonempty) begin
            upd_d = 1'b1;
            out_d = head_ent;
            if (res0_valid_i) begin
                wa_req = 1'b1;
                wa_ent = lane0_ent;
                wb_req = res1_valid_i;
                wb_ent = lane1_ent;
            end else if (res1_valid_i) begin
                wa_req = 1'b1;
                wa_ent = lane1_ent;
            end
        end else if (res0_valid_i) begin
            upd_d  = 1'b1;
            out_d  = lane0_ent;
            wa_req = res1_valid_i;
            wa_ent = lane1_ent;
        end else if (res1_valid_i) begin
            upd_d = 1'b1;
            out_d = lane1_ent;
        end
        if (flush_i) begin
            upd_d  = 1'b0;
            out_d  = out_q;
            wa_req = 1'b0;
            wb_req = 1'b0;
        end
    end

    // Room is judged against the occupancy at the start of the cycle; the
    // same-cycle pop does not lend its slot to an incoming write. Slot b is
    // only ever requested together with slot a, so dropping b first keeps
    // the youngest-goes-first rule.
    assign wa_en = wa_req && (count_q < DEPTH_C);
    assign wb_en = wb_req && (count_q <= DEPTH_M2);
    assign drop  = (wa_req && !wa_en) || (wb_req && !wb_en);
    assign n_wr  = {1'b0, wa_en} + {1'b0, wb_en};
    assign pop   = fifo_nonempty && !flush_i;

    always_comb begin
        ovf_d    = ovf_q | drop;
        count_d  = count_q + CNT_W'(n_wr) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            upd_q    <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            upd_q    <= upd_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (wa_en) begin
                mem_q[wr_ptr_q] <= wa_ent;
            end
            if (wb_en) begin
                mem_q[wr_ptr_p1] <= wb_ent;
            end
        end
    end

    assign res_ready_o        = (count_q <= DEPTH_M2);
    assign br_update_o        = upd_q;
    assign br_update_taken_o  = out_q[64];
    assign br_update_PC_o     = out_q[63:32];
    assign br_update_target_o = out_q[31:0];
    assign count_o            = count_q;
    assign overflow_o         = ovf_q;

endmodule
